plic_scan_arb: RTL and testbench
================================

PLIC_SCAN_ARB -- requirements
Module: plic_scan_arb

Interface
REQ-001 SHALL have parameter SRC_COUNT, default PLIC_SOURCE_COUNT, number of interrupt sources; index 0 is reserved and means "none".
REQ-002 SHALL have parameter TGT_COUNT, default PLIC_TARGET_COUNT, number of targets.
REQ-003 SHALL have parameter PRIO_W, default PLIC_PRIO_WIDTH, priority width.
REQ-004 SHALL have parameter SRC_W, default PLIC_SOURCE_WIDTH, source index width.
REQ-005 clk  in  1  sole clock; all state is updated on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 scan_en_i  in  1  scan enable.
REQ-008 irq_pending_i  in  SRC_COUNT  gateway pending bits.
REQ-009 regs_ie_i  in  TGT_COUNT x SRC_COUNT  per-target interrupt enables.
REQ-010 regs_prio_i  in  SRC_COUNT x PRIO_W  per-source priority.
REQ-011 regs_prio_th_i  in  TGT_COUNT x PRIO_W  per-target threshold.
REQ-012 claim_req_i  in  TGT_COUNT  one-cycle claim pulse per target.
REQ-013 claim_idx_o  out  TGT_COUNT x SRC_W  registered winning source per target.
REQ-014 irq_req_o  out  TGT_COUNT  registered interrupt request per target.
REQ-015 scan_busy_o  out  1  high while state is SCAN or COMMIT.

Function
REQ-016 FSM states SHALL be IDLE, SCAN and COMMIT, with a target counter tgt_q and a source counter src_q of width SRC_W.
REQ-017 IDLE SHALL go to SCAN when scan_en_i=1, loading src_q=1, best_idx=0 and best_prio=0.
REQ-018 In each SCAN cycle, source src_q is a candidate if irq_pending_i[src_q], regs_ie_i[tgt_q][src_q] and regs_prio_i[src_q] > best_prio are all true; a candidate SHALL load best_idx and best_prio.
- The strict > means ties resolve to the lower index.
- A priority of 0 never wins.
REQ-019 SCAN SHALL increment src_q each cycle, and SHALL go to COMMIT after evaluating src_q = SRC_COUNT-1.
REQ-020 COMMIT SHALL write claim_idx_o[tgt_q]=best_idx and irq_req_o[tgt_q]=1 if best_prio > regs_prio_th_i[tgt_q]; otherwise it SHALL write 0 and 0.
REQ-021 COMMIT SHALL then advance tgt_q, wrapping from TGT_COUNT-1 to 0, and return to SCAN with src_q=1 and best cleared, or to IDLE if scan_en_i=0.
REQ-022 Latency SHALL be SRC_COUNT cycles per target: SRC_COUNT-1 SCAN cycles plus 1 COMMIT cycle. Outputs for a target SHALL refresh every TGT_COUNT*SRC_COUNT cycles.
REQ-023 claim_idx_o SHALL hold its value during the cycle claim_req_i[t]=1, so the gateway samples the correct index.
REQ-024 On the edge ending a claim_req_i[t] cycle, claim_idx_o[t] and irq_req_o[t] SHALL clear to 0.
- If tgt_q==t, the scan SHALL restart at src_q=1 with best cleared.
REQ-025 If a claim for t and a COMMIT for t occur in the same cycle, the claim SHALL win: the commit is discarded and the scan restarts.
REQ-026 Claims for targets other than tgt_q SHALL NOT disturb the scan in progress. Several claim bits may be set in one cycle.
REQ-027 scan_en_i=0 during SCAN SHALL abort to IDLE; outputs hold their last committed values, and claims are still honoured.
REQ-028 Input changes during a scan SHALL take effect from the next source evaluated; no snapshot is taken.

Reset
REQ-029 While rst=1, state SHALL be IDLE, tgt_q=0, src_q=0, best cleared, and claim_idx_o, irq_req_o and scan_busy_o SHALL all be 0, asynchronously.
REQ-030 When scan_en_i=1, the first SCAN cycle SHALL be the first rising edge after rst deasserts.

Structure
REQ-031 PLIC_SOURCE_COUNT, PLIC_TARGET_COUNT, PLIC_PRIO_WIDTH, PLIC_SOURCE_WIDTH and the FSM state enum SHALL live in the shared PLIC defines package.
REQ-032 There SHALL be no sub-module; one FSM serves all targets, as a drop-in sequential replacement for the per-target combinational resolvers.
REQ-033 The block SHALL require SRC_COUNT >= 2 and TGT_COUNT >= 1.

Verification
REQ-034 Every scenario below SHALL use SRC_COUNT=8, TGT_COUNT=2, PRIO_W=3 and scan_en_i=1.
REQ-035 Scenario 1: src 3 pending, prio 5, ie[0][3]=1, th[0]=2, ie[1]=0 -> claim_idx_o[0]=3 and irq_req_o[0]=1 within 16 cycles; target 1 outputs stay 0.
REQ-036 Scenario 2: srcs 2 and 6 pending, both prio 4, th=0 -> claim_idx_o[0]=2.
REQ-037 Scenario 3: src 5 prio 3, th[0]=3 -> irq_req_o[0]=0 and claim_idx_o[0]=0; then th[0]=2 -> 1 and 5 within 16 cycles.
REQ-038 Scenario 4: claim_req_i[0] pulse while tgt_q=0, mid-scan, with pending dropped on the next cycle -> idx held in the claim cycle, outputs 0 the next cycle, src_q=1, and no reassertion.
REQ-039 Scenario 5: src 0 pending with prio 7 and ie set -> ignored, claim_idx_o=0.
REQ-040 Scenario 6: rst pulsed mid-SCAN with outputs set -> all outputs 0 immediately, before any clock edge; scan resumes from tgt 0.

Source files
------------

// File: rtl/plic_scan_arb_pkg.sv
// Shared PLIC defines: default geometry of the interrupt controller and the
// state encoding of the sequential priority-scan arbiter.
package plic_scan_arb_pkg;

    localparam int unsigned PLIC_SOURCE_COUNT = 8;  // source 0 is reserved ("none")
    localparam int unsigned PLIC_TARGET_COUNT = 2;
    localparam int unsigned PLIC_PRIO_WIDTH   = 3;
    localparam int unsigned PLIC_SOURCE_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } plic_scan_state_e;

endpackage

// File: rtl/plic_scan_arb.sv
// Sequential PLIC priority resolver. One FSM walks every target in turn,
// scanning sources 1..SRC_COUNT-1 (one per cycle), then commits the highest
// priority enabled pending source for that target if it beats the threshold.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   scan_en_i       scan enable; dropping it returns the FSM to idle
//   irq_pending_i   gateway pending bits, one per source
//   regs_ie_i       per-target, per-source interrupt enables
//   regs_prio_i     per-source priority
//   regs_prio_th_i  per-target priority threshold
//   claim_req_i     one-cycle claim pulse per target
//   claim_idx_o     registered winning source per target (0 = none)
//   irq_req_o       registered interrupt request per target
//   scan_busy_o     high while the FSM is scanning or committing
module plic_scan_arb
    import plic_scan_arb_pkg::*;
#(
    parameter int unsigned SRC_COUNT = PLIC_SOURCE_COUNT,
    parameter int unsigned TGT_COUNT = PLIC_TARGET_COUNT,
    parameter int unsigned PRIO_W    = PLIC_PRIO_WIDTH,
    parameter int unsigned SRC_W     = PLIC_SOURCE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 scan_en_i,
    input  logic [SRC_COUNT-1:0]                 irq_pending_i,
    input  logic [TGT_COUNT-1:0][SRC_COUNT-1:0]  regs_ie_i,
    input  logic [SRC_COUNT-1:0][PRIO_W-1:0]     regs_prio_i,
    input  logic [TGT_COUNT-1:0][PRIO_W-1:0]     regs_prio_th_i,
    input  logic [TGT_COUNT-1:0]                 claim_req_i,
    output logic [TGT_COUNT-1:0][SRC_W-1:0]      claim_idx_o,
    output logic [TGT_COUNT-1:0]                 irq_req_o,
    output logic                                 scan_busy_o
);

    localparam int unsigned TGT_W = (TGT_COUNT > 1) ? $clog2(TGT_COUNT) : 1;

    if (SRC_COUNT < 2 || TGT_COUNT < 1) begin : g_bad_params
        $error("plic_scan_arb needs SRC_COUNT >= 2 and TGT_COUNT >= 1");
    end

    plic_scan_state_e                 state_q, state_d;
    logic [TGT_W-1:0]                 tgt_q, tgt_d;
    logic [SRC_W-1:0]                 src_q, src_d;
    logic [SRC_W-1:0]                 best_idx_q, best_idx_d;
    logic [PRIO_W-1:0]                best_prio_q, best_prio_d;
    logic [TGT_COUNT-1:0][SRC_W-1:0]  claim_idx_q, claim_idx_d;
    logic [TGT_COUNT-1:0]             irq_q, irq_d;

    logic cand;
    logic claim_self;

    // Strict '>' against the running best: ties keep the lower index and a
    // priority of 0 can never beat the cleared best of 0.
    assign cand = irq_pending_i[src_q] && regs_ie_i[tgt_q][src_q] &&
                  (regs_prio_i[src_q] > best_prio_q);

    assign claim_self = claim_req_i[tgt_q];

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        src_d       = src_q;
        best_idx_d  = best_idx_q;
        best_prio_d = best_prio_q;
        claim_idx_d = claim_idx_q;
        irq_d       = irq_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_en_i) begin
                    state_d     = ST_SCAN;
                    src_d       = SRC_W'(1);
                    best_idx_d  = '0;
                    best_prio_d = '0;
                end
            end
            ST_SCAN: begin
                if (!scan_en_i) begin
                    state_d = ST_IDLE;
                end else if (claim_self) begin
                    // The current target was just claimed: its partial result is stale.
                    src_d       = SRC_W'(1);
                    best_idx_d  = '0;
                    best_prio_d = '0;
                end else begin
                    if (cand) begin
                        best_idx_d  = src_q;
                        best_prio_d = regs_prio_i[src_q];
                    end
                    if (src_q == SRC_W'(SRC_COUNT - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        src_d = src_q + SRC_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // A simultaneous claim discards the commit and rescans the same target.
                if (!claim_self) begin
                    if (best_prio_q > regs_prio_th_i[tgt_q]) begin
                        claim_idx_d[tgt_q] = best_idx_q;
                        irq_d[tgt_q]       = 1'b1;
                    end else begin
                        claim_idx_d[tgt_q] = '0;
                        irq_d[tgt_q]       = 1'b0;
                    end
                    tgt_d = (tgt_q == TGT_W'(TGT_COUNT - 1)) ? '0 : tgt_q + TGT_W'(1);
                end
                src_d       = SRC_W'(1);
                best_idx_d  = '0;
                best_prio_d = '0;
                state_d     = scan_en_i ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Claims clear their target last so they override a same-cycle commit.
        for (int unsigned t = 0; t < TGT_COUNT; t++) begin
            if (claim_req_i[t]) begin
                claim_idx_d[t] = '0;
                irq_d[t]       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            src_q       <= '0;
            best_idx_q  <= '0;
            best_prio_q <= '0;
            claim_idx_q <= '0;
            irq_q       <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            src_q       <= src_d;
            best_idx_q  <= best_idx_d;
            best_prio_q <= best_prio_d;
            claim_idx_q <= claim_idx_d;
            irq_q       <= irq_d;
        end
    end

    assign claim_idx_o = claim_idx_q;
    assign irq_req_o   = irq_q;
    assign scan_busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_plic_scan_arb.sv
module tb_plic_scan_arb;

    localparam int unsigned SC = 8;
    localparam int unsigned TC = 2;
    localparam int unsigned PW = 3;
    localparam int unsigned SW = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    scan_en;
    logic [SC-1:0]           pend;
    logic [TC-1:0][SC-1:0]   ie;
    logic [SC-1:0][PW-1:0]   prio;
    logic [TC-1:0][PW-1:0]   th;
    logic [TC-1:0]           claim;
    logic [TC-1:0][SW-1:0]   idx_o;
    logic [TC-1:0]           irq_o;
    logic                    busy_o;

    int tests = 0;
    int fails = 0;

    plic_scan_arb #(
        .SRC_COUNT (SC),
        .TGT_COUNT (TC),
        .PRIO_W    (PW),
        .SRC_W     (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .scan_en_i      (scan_en),
        .irq_pending_i  (pend),
        .regs_ie_i      (ie),
        .regs_prio_i    (prio),
        .regs_prio_th_i (th),
        .claim_req_i    (claim),
        .claim_idx_o    (idx_o),
        .irq_req_o      (irq_o),
        .scan_busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each target slot takes SC cycles. During the slot the
    // effective priority of every source is recorded at the cycle it is
    // visited; the slot result is the argmax of that record (lowest index on
    // ties, zero never wins) compared against the threshold.
    int m_busy = 0;
    int m_tgt  = 0;
    int m_pos  = 0;   // 1..SC-1 = source visited next, SC = commit cycle
    int rec[SC];
    int m_idx[TC];
    int m_irq[TC];
    int best, bi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_tgt = 0; m_pos = 0;
            for (int s = 0; s < SC; s++) rec[s] = 0;
            for (int t = 0; t < TC; t++) begin m_idx[t] = 0; m_irq[t] = 0; end
        end else begin
            if (m_busy == 0) begin
                if (scan_en) begin
                    m_busy = 1; m_pos = 1;
                    for (int s = 0; s < SC; s++) rec[s] = 0;
                end
            end else if (m_pos < SC) begin
                if (!scan_en) begin
                    m_busy = 0;
                end else if (claim[m_tgt]) begin
                    m_pos = 1;
                    for (int s = 0; s < SC; s++) rec[s] = 0;
                end else begin
                    rec[m_pos] = (pend[m_pos] && ie[m_tgt][m_pos]) ? int'(prio[m_pos]) : 0;
                    m_pos++;
                end
            end else begin
                if (!claim[m_tgt]) begin
                    best = 0; bi = 0;
                    for (int s = 1; s < SC; s++)
                        if (rec[s] > best) begin best = rec[s]; bi = s; end
                    if (best > int'(th[m_tgt])) begin
                        m_idx[m_tgt] = bi; m_irq[m_tgt] = 1;
                    end else begin
                        m_idx[m_tgt] = 0; m_irq[m_tgt] = 0;
                    end
                    m_tgt = (m_tgt + 1) % TC;
                end
                m_pos = 1;
                for (int s = 0; s < SC; s++) rec[s] = 0;
                m_busy = scan_en ? 1 : 0;
            end
            for (int t = 0; t < TC; t++)
                if (claim[t]) begin m_idx[t] = 0; m_irq[t] = 0; end
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        for (int t = 0; t < TC; t++) begin
            chk($sformatf("model idx[%0d]", t), int'(idx_o[t]), m_idx[t]);
            chk($sformatf("model irq[%0d]", t), int'(irq_o[t]), m_irq[t]);
        end
        chk("model busy", int'(busy_o), m_busy);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_inputs();
        pend = '0; ie = '0; prio = '0; th = '0; claim = '0; scan_en = 1'b1;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_for(input string name, input int t, input int e_idx,
                            input int e_irq, input int bound);
        int k;
        k = 0;
        while (k < bound && !(int'(idx_o[t]) == e_idx && int'(irq_o[t]) == e_irq)) begin
            @(negedge clk);
            k++;
        end
        chk({name, " idx"}, int'(idx_o[t]), e_idx);
        chk({name, " irq"}, int'(irq_o[t]), e_irq);
    endtask

    initial begin
        clr_inputs();

        // Scenario 1: single source for target 0, target 1 disabled
        pend[3] = 1'b1; prio[3] = 3'd5; ie[0][3] = 1'b1; th[0] = 3'd2;
        do_reset();
        chk("reset busy", int'(busy_o), 0);
        cyc(8);
        chk("s1 irq0 before commit", int'(irq_o[0]), 0);
        cyc(1);
        chk("s1 idx0 first commit", int'(idx_o[0]), 3);
        chk("s1 irq0 first commit", int'(irq_o[0]), 1);
        cyc(16);
        chk("s1 idx1", int'(idx_o[1]), 0);
        chk("s1 irq1", int'(irq_o[1]), 0);

        // Scenario 4: claim target 0 mid-scan, then drop pending
        cyc(12);
        claim[0] = 1'b1;
        chk("s4 idx held in claim cycle", int'(idx_o[0]), 3);
        chk("s4 irq held in claim cycle", int'(irq_o[0]), 1);
        cyc(1);
        claim[0] = 1'b0; pend[3] = 1'b0;
        chk("s4 idx cleared", int'(idx_o[0]), 0);
        chk("s4 irq cleared", int'(irq_o[0]), 0);
        cyc(20);
        chk("s4 irq not reasserted", int'(irq_o[0]), 0);

        // Scenario 2: tie on priority resolves to the lower index
        clr_inputs();
        pend[2] = 1'b1; pend[6] = 1'b1; prio[2] = 3'd4; prio[6] = 3'd4; ie[0] = '1;
        do_reset();
        wait_for("s2", 0, 2, 1, 16);

        // Scenario 3: priority equal to threshold does not fire
        clr_inputs();
        pend[5] = 1'b1; prio[5] = 3'd3; ie[0][5] = 1'b1; th[0] = 3'd3;
        do_reset();
        cyc(10);
        chk("s3 idx0 at threshold", int'(idx_o[0]), 0);
        chk("s3 irq0 at threshold", int'(irq_o[0]), 0);
        th[0] = 3'd2;
        wait_for("s3 lowered th", 0, 5, 1, 16);

        // Scenario 5: source 0 is never a candidate
        clr_inputs();
        pend[0] = 1'b1; prio[0] = 3'd7; ie[0][0] = 1'b1; ie[1][0] = 1'b1;
        do_reset();
        cyc(20);
        chk("s5 idx0", int'(idx_o[0]), 0);
        chk("s5 irq0", int'(irq_o[0]), 0);

        // Two targets, double claim, mid-scan input change, scan abort
        clr_inputs();
        pend = 8'b1010_0110;
        prio[1] = 3'd2; prio[2] = 3'd6; prio[5] = 3'd6; prio[7] = 3'd7;
        ie[0] = 8'b0010_0110; ie[1] = 8'b1010_0010;
        th[0] = 3'd5; th[1] = 3'd6;
        do_reset();
        cyc(18);
        chk("mt idx0", int'(idx_o[0]), 2);
        chk("mt irq0", int'(irq_o[0]), 1);
        chk("mt idx1", int'(idx_o[1]), 7);
        chk("mt irq1", int'(irq_o[1]), 1);
        claim = 2'b11;
        cyc(1);
        claim = 2'b00;
        chk("mt double claim irq0", int'(irq_o[0]), 0);
        chk("mt double claim irq1", int'(irq_o[1]), 0);
        cyc(3);
        prio[2] = 3'd1;
        cyc(4);
        scan_en = 1'b0;
        cyc(2);
        chk("abort busy", int'(busy_o), 0);
        cyc(3);
        scan_en = 1'b1;
        cyc(40);
        chk("mt idx0 after prio change", int'(idx_o[0]), 5);
        chk("mt idx1 steady", int'(idx_o[1]), 7);

        // Scenario 6: asynchronous reset mid-scan
        cyc(3);
        chk("s6 busy before reset", int'(busy_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6 async idx0", int'(idx_o[0]), 0);
        chk("s6 async irq0", int'(irq_o[0]), 0);
        chk("s6 async irq1", int'(irq_o[1]), 0);
        chk("s6 async busy", int'(busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(9);
        chk("s6 tgt0 first idx", int'(idx_o[0]), 5);
        chk("s6 tgt1 not yet", int'(irq_o[1]), 0);
        cyc(8);
        chk("s6 tgt1 idx", int'(idx_o[1]), 7);
        chk("s6 tgt1 irq", int'(irq_o[1]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
